// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module : alu_arbiter
// Brief  : Round-robin sharing of one registered-output ALU between requesters
// Rev    : 1.0
// ============================================================================
module alu_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_inOne,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_inTwo,
  input  logic [NUM_REQ*OP_WIDTH-1:0]   req_opcode,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_result,
  output logic                          resp_zero,
  output logic                          resp_carry,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         alu_inOne,
  output logic [DATA_WIDTH-1:0]         alu_inTwo,
  output logic [OP_WIDTH-1:0]           alu_opcode,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          alu_zeroFlag,
  input  logic                          alu_carryBit
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_owner;
  logic [IDX_W-1:0]      r_lastGrant;
  logic [NUM_REQ-1:0]    r_respValid;
  logic [DATA_WIDTH-1:0] r_aluInOne;
  logic [DATA_WIDTH-1:0] r_aluInTwo;
  logic [OP_WIDTH-1:0]   r_aluOpcode;

  logic                  w_ownerReady;
  logic                  w_window;
  logic                  w_found;
  logic                  w_accept;
  logic [IDX_W-1:0]      w_winner;
  logic [DATA_WIDTH-1:0] w_selInOne;
  logic [DATA_WIDTH-1:0] w_selInTwo;
  logic [OP_WIDTH-1:0]   w_selOpcode;

  assign w_ownerReady = resp_ready[r_owner];
  assign w_window     = (r_state == IDLE) || ((r_state == RESP) && w_ownerReady);
  assign w_accept     = w_window && w_found;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    int idx;
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(r_lastGrant) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!w_found && req_valid[idx]) begin
        w_winner = IDX_W'(idx);
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_selInOne  = '0;
    w_selInTwo  = '0;
    w_selOpcode = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDX_W'(i)) begin
        w_selInOne  = req_inOne[i*DATA_WIDTH +: DATA_WIDTH];
        w_selInTwo  = req_inTwo[i*DATA_WIDTH +: DATA_WIDTH];
        w_selOpcode = req_opcode[i*OP_WIDTH +: OP_WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_lastGrant <= IDX_W'(NUM_REQ - 1);
      r_respValid <= '0;
      r_aluInOne  <= '0;
      r_aluInTwo  <= '0;
      r_aluOpcode <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_state     <= RESP;
          r_respValid <= NUM_REQ'(1) << r_owner;
        end
        RESP: begin
          // A new grant in the release cycle chains straight into EXEC.
          if (w_ownerReady) begin
            r_respValid <= '0;
            r_state     <= w_accept ? EXEC : IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_respValid <= '0;
        end
      endcase
      if (w_accept) begin
        r_owner     <= w_winner;
        r_lastGrant <= w_winner;
        r_aluInOne  <= w_selInOne;
        r_aluInTwo  <= w_selInTwo;
        r_aluOpcode <= w_selOpcode;
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign resp_valid  = r_respValid;
  assign alu_inOne   = r_aluInOne;
  assign alu_inTwo   = r_aluInTwo;
  assign alu_opcode  = r_aluOpcode;
  assign resp_result = (r_state == RESP) ? alu_result : '0;
  assign resp_zero   = (r_state == RESP) ? alu_zeroFlag : 1'b0;
  assign resp_carry  = (r_state == RESP) ? alu_carryBit : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_arbiter
// Brief  : Self-checking bench for alu_arbiter with a behavioural ALU attached
// Rev    : 1.0
// ============================================================================
module tb_alu_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int OW = 4;

  localparam logic [OW-1:0] OP_AND = 4'b0000;
  localparam logic [OW-1:0] OP_OR  = 4'b0001;
  localparam logic [OW-1:0] OP_ADD = 4'b0010;
  localparam logic [OW-1:0] OP_SUB = 4'b0110;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_inOne = '0;
  logic [N*DW-1:0] req_inTwo = '0;
  logic [N*OW-1:0] req_opcode = '0;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready = '0;
  logic [DW-1:0]   resp_result;
  logic            resp_zero;
  logic            resp_carry;
  logic            busy;
  logic [DW-1:0]   alu_inOne;
  logic [DW-1:0]   alu_inTwo;
  logic [OW-1:0]   alu_opcode;
  logic [DW-1:0]   alu_result;
  logic            alu_zeroFlag;
  logic            alu_carryBit;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_inOne(req_inOne), .req_inTwo(req_inTwo), .req_opcode(req_opcode),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_carry(resp_carry),
    .busy(busy),
    .alu_inOne(alu_inOne), .alu_inTwo(alu_inTwo), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zeroFlag(alu_zeroFlag), .alu_carryBit(alu_carryBit)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] aluFn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return '0;
    endcase
  endfunction

  function automatic logic carryFn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW];
  endfunction

  // Stand-in ALU: result registered, flags combinational on the held operands.
  always @(posedge clock) alu_result <= aluFn(alu_opcode, alu_inOne, alu_inTwo);
  assign alu_zeroFlag = (alu_inTwo == '0);
  assign alu_carryBit = carryFn(alu_inOne, alu_inTwo);

  // Transaction-level reference state
  bit            mBusy = 0;
  int            mAge = 0;
  int            mOwner = 0;
  int            mLast = N - 1;
  logic [DW-1:0] mA = '0, mB = '0, mRes = '0;
  logic [OW-1:0] mOp = '0;
  logic          mZero = 1'b0, mCarry = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rrPick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic setReq(input int i, input logic [OW-1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
    req_opcode[i*OW +: OW] = op;
    req_inOne[i*DW +: DW]  = a;
    req_inTwo[i*DW +: DW]  = b;
  endtask

  // Compare all outputs with the reference, then advance one clock (ends at negedge).
  task automatic step();
    logic [N-1:0] eReady, eValid;
    bit present, window;
    int w;
    #1;
    present = mBusy && (mAge >= 1);
    eValid = '0;
    if (present) eValid[mOwner] = 1'b1;
    window = !mBusy || (present && resp_ready[mOwner]);
    w = rrPick(req_valid, mLast);
    eReady = '0;
    if (window && w >= 0) eReady[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(eReady));
    chk("resp_valid", 64'(resp_valid), 64'(eValid));
    chk("busy", 64'(busy), 64'(mBusy));
    chk("alu_inOne", 64'(alu_inOne), 64'(mA));
    chk("alu_inTwo", 64'(alu_inTwo), 64'(mB));
    chk("alu_opcode", 64'(alu_opcode), 64'(mOp));
    if (present) begin
      chk("resp_result", 64'(resp_result), 64'(mRes));
      chk("resp_zero", 64'(resp_zero), 64'(mZero));
      chk("resp_carry", 64'(resp_carry), 64'(mCarry));
    end
    @(posedge clock);
    if (reset) begin
      mBusy = 0; mAge = 0; mOwner = 0; mLast = N - 1;
      mA = '0; mB = '0; mOp = '0;
    end else if (window && w >= 0) begin
      mBusy = 1; mAge = 0; mOwner = w; mLast = w;
      mA = req_inOne[w*DW +: DW];
      mB = req_inTwo[w*DW +: DW];
      mOp = req_opcode[w*OW +: OW];
      mRes = aluFn(mOp, mA, mB);
      mZero = (mB == '0);
      mCarry = carryFn(mA, mB);
    end else if (present && resp_ready[mOwner]) begin
      mBusy = 0;
    end else if (mBusy) begin
      mAge = 1;
    end
    @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b1;
    req_valid = '0;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          z;
    logic          c;
  } vec_t;

  vec_t vecs[6];
  logic [N-1:0] grantSeq[8];
  logic [OW-1:0] opPool[6];

  initial begin
    vecs[0] = '{OP_ADD, 32'd5,          32'd3,          32'd8,          1'b0, 1'b0};
    vecs[1] = '{OP_SUB, 32'd3,          32'd5,          32'hFFFFFFFE,   1'b0, 1'b0};
    vecs[2] = '{OP_AND, 32'hDEADBEEF,   32'd0,          32'd0,          1'b1, 1'b0};
    vecs[3] = '{4'hF,   32'd7,          32'd9,          32'd0,          1'b0, 1'b0};
    vecs[4] = '{OP_ADD, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1'b1};
    vecs[5] = '{OP_OR,  32'hF0F00000,   32'h0F0F1234,   32'hFFFF1234,   1'b0, 1'b0};
    grantSeq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    opPool = '{OP_AND, OP_OR, OP_ADD, OP_SUB, 4'hF, 4'h9};

    // Reset state
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_alu_inOne", 64'(alu_inOne), 64'd0);
    chk("rst_resp_result", 64'(resp_result), 64'd0);
    step();
    reset = 1'b0;

    // Single transactions on requester 0, latency and result checked per vector
    foreach (vecs[v]) begin
      setReq(0, vecs[v].op, vecs[v].a, vecs[v].b);
      req_valid = 2'b01;
      resp_ready = 2'b01;
      #1 chk("vec_grant", 64'(req_ready), 64'(2'b01));
      step();
      req_valid = 2'b00;
      #1 chk("vec_exec_valid", 64'(resp_valid), 64'd0);
      chk("vec_exec_busy", 64'(busy), 64'd1);
      step();
      #1 chk("vec_resp_valid", 64'(resp_valid), 64'(2'b01));
      chk("vec_result", 64'(resp_result), 64'(vecs[v].res));
      chk("vec_zero", 64'(resp_zero), 64'(vecs[v].z));
      chk("vec_carry", 64'(resp_carry), 64'(vecs[v].c));
      step();
      #1 chk("vec_idle_busy", 64'(busy), 64'd0);
    end

    // Two continuous requesters alternate, one accept every two cycles
    doReset();
    setReq(0, OP_ADD, 32'd1, 32'd2);
    setReq(1, OP_ADD, 32'd10, 32'd20);
    req_valid = 2'b11;
    resp_ready = 2'b11;
    for (int c = 0; c < 8; c++) begin
      #1 chk("rr_grant", 64'(req_ready), 64'(grantSeq[c]));
      step();
    end
    req_valid = 2'b00;
    step(); step();

    // Backpressure on requester 1 holds the response and blocks new grants
    doReset();
    setReq(1, OP_SUB, 32'd3, 32'd5);
    setReq(0, OP_ADD, 32'd4, 32'd4);
    req_valid = 2'b10;
    resp_ready = 2'b00;
    step();
    req_valid = 2'b01;
    step();
    resp_ready = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_result", 64'(resp_result), 64'h00000000FFFFFFFE);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_valid", 64'(resp_valid), 64'(2'b10));
      step();
    end
    resp_ready = 2'b11;
    #1 chk("bp_release_grant", 64'(req_ready), 64'(2'b01));
    step();
    req_valid = 2'b00;
    step(); step(); step();

    // Reset during EXEC drops the transaction
    setReq(1, OP_ADD, 32'd9, 32'd9);
    req_valid = 2'b10;
    step();
    reset = 1'b1;
    req_valid = 2'b00;
    step();
    reset = 1'b0;
    #1 chk("rx_valid", 64'(resp_valid), 64'd0);
    chk("rx_busy", 64'(busy), 64'd0);
    chk("rx_alu_inOne", 64'(alu_inOne), 64'd0);
    chk("rx_alu_opcode", 64'(alu_opcode), 64'd0);
    step();
    req_valid = 2'b11;
    #1 chk("rx_first_grant", 64'(req_ready), 64'(2'b01));
    step();
    req_valid = 2'b00;
    step(); step(); step();

    // Release and new grant in the same cycle: no idle cycle in between
    doReset();
    setReq(0, OP_ADD, 32'd1, 32'd1);
    setReq(1, OP_OR, 32'h00000055, 32'h000000A0);
    resp_ready = 2'b00;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    resp_ready = 2'b01;
    req_valid = 2'b10;
    #1 chk("b2b_grant", 64'(req_ready), 64'(2'b10));
    step();
    req_valid = 2'b00;
    #1 chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_alu_inOne", 64'(alu_inOne), 64'h55);
    step();
    resp_ready = 2'b11;
    #1 chk("b2b_result", 64'(resp_result), 64'hF5);
    step();

    // Randomized traffic against the reference
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      req_valid = N'($urandom);
      resp_ready = N'($urandom);
      if ($urandom_range(0, 3) != 0) resp_ready = '1;
      for (int i = 0; i < N; i++) begin
        setReq(i, opPool[$urandom_range(0, 5)], $urandom,
               ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom));
      end
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
